// File: rtl/seq_multiplier_ctrl.sv
// Shift-and-add unsigned multiplier controller: one conditional add and one shift per CALC cycle.
// Optional macro SEQ_MULTIPLIER_CTRL_EARLY_EXIT_EN finishes early once the remaining multiplier bits are zero.
module seq_multiplier_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   Out,
   output logic                 Cout,
   output logic [1:0]           dbg_state
);

   // Handshake: start is accepted only on an edge seen in IDLE (busy=0); done is a
   // one-cycle pulse with Out valid, and Out then holds until the next accepted start.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   acc, acc_step, acc_nxt;
   logic [WIDTH:0]       sum;
   logic [CW-1:0]        count;
   logic                 last;
`ifdef SEQ_MULTIPLIER_CTRL_EARLY_EXIT_EN
   logic [WIDTH-1:0]     rem;
   logic                 early;
`endif

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
      acc_step = {sum, acc[WIDTH-1:1]};
      acc_nxt  = acc_step;
      last     = (count == CW'(WIDTH-1));
`ifdef SEQ_MULTIPLIER_CTRL_EARLY_EXIT_EN
      // Low half holds product bits above the unconsumed multiplier bits; strip them off.
      rem      = acc[WIDTH-1:0] << count;
      rem      = rem >> count;
      early    = (rem[WIDTH-1:1] == '0);
      if (early) begin
         acc_nxt = acc_step >> (CW'(WIDTH-1) - count);
         last    = 1'b1;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    if (done)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // DONE spans two cycles: the first registers Out and raises done, the second drops it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand <= '0;
         acc   <= '0;
         count <= '0;
         Cout  <= 1'b0;
         Out   <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= A;
                  acc   <= {{WIDTH{1'b0}}, B};
                  count <= '0;
                  Cout  <= 1'b0;
               end
            end
            CALC: begin
               acc   <= acc_nxt;
               Cout  <= sum[WIDTH];
               count <= count + 1'b1;
            end
            DONE: begin
               if (!done) begin
                  Out  <= acc;
                  done <= 1'b1;
               end else begin
                  done <= 1'b0;
               end
            end
            default: done <= 1'b0;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Scoreboard bench for seq_multiplier_ctrl: directed operand pairs with hand-computed products,
// completion edge and, where build-independent, final adder carry.
module tb_seq_multiplier_ctrl;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst, start;
   logic [W-1:0]   a, b;
   logic           busy, done, cout;
   logic [2*W-1:0] out;
   logic [1:0]     dbg_state;

   seq_multiplier_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
      .busy(busy), .done(done), .Out(out), .Cout(cout), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2*W-1:0] exp_q[$];
   int             exp_cyc_q[$];
   int             exp_cout_q[$];
   logic [2*W-1:0] last_prod;
   int             n_vec = 0;
   int             n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Edges from the start edge to the cycle in which done is visible.
   function automatic int lat(input logic [W-1:0] bb);
      int h;
      h = 0;
`ifdef SEQ_MULTIPLIER_CTRL_EARLY_EXIT_EN
      for (int i = 0; i < W; i++) if (bb[i]) h = i;
      return h + 2;
`else
      h = W + 1;
      return h;
`endif
   endfunction

   always @(negedge clk) begin
      logic [2*W-1:0] p;
      int             c, ec;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            p  = exp_q.pop_front();
            c  = exp_cyc_q.pop_front();
            ec = exp_cout_q.pop_front();
            check("product", 32'(out), 32'(p));
            check("done_cycle", 32'(cyc), 32'(c));
            check("busy_at_done", 32'(busy), 32'd1);
            if (ec >= 0) check("cout", 32'(cout), 32'(ec));
         end
      end
   end

   task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [2*W-1:0] prod, input int ec);
      @(negedge clk);
      a = aa; b = bb; start = 1'b1;
      exp_q.push_back(prod);
      exp_cyc_q.push_back(cyc + 1 + lat(bb));
      exp_cout_q.push_back(ec);
      last_prod = prod;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom_range(0, 2**W - 1));
      b = W'($urandom_range(0, 2**W - 1));
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         check("done_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete(); exp_cyc_q.delete(); exp_cout_q.delete();
      end
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("out_hold", 32'(out), 32'(last_prod));
   endtask

   initial begin
      int n, p;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; last_prod = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out",  32'(out),  32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;

      issue(4'b0000, 4'b0000, 8'h00, 0);  drain();
      issue(4'b1011, 4'b1010, 8'h6E, 0);  drain();
      issue(4'b1111, 4'b1111, 8'hE1, 1);  drain();
      issue(4'b1110, 4'b0101, 8'h46, -1); drain();

      // Second start lands while busy and must be ignored.
      issue(4'b1111, 4'b1001, 8'h87, -1);
      @(negedge clk);
      a = 4'b0001; b = 4'b0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset in the middle of an operation discards it, including Out.
      issue(4'b0110, 4'b0011, 8'h12, -1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_out",  32'(out),  32'd0);
      exp_q.delete(); exp_cyc_q.delete(); exp_cout_q.delete();
      @(negedge clk);
      rst = 1'b0;
      issue(4'b1000, 4'b1100, 8'h60, -1); drain();

      // start held high: accepted again on the first IDLE edge after each result.
      @(negedge clk);
      a = 4'b0100; b = 4'b0101; start = 1'b1;
      n = cyc + 1;
      p = lat(4'b0101) + 2;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'h14);
         exp_cyc_q.push_back(n + k * p + lat(4'b0101));
         exp_cout_q.push_back(-1);
      end
      last_prod = 8'h14;
      while (cyc < n + 2 * p) @(negedge clk);
      start = 1'b0;
      drain();

      issue(4'b0011, 4'b0001, 8'h03, -1); drain();
      issue(4'b0011, 4'b0000, 8'h00, 0);  drain();
      issue(4'b1111, 4'b1000, 8'h78, 0);  drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
